shift_reg_sequencer: RTL and testbench

Control sequencer for the row-feed shift registers of the systolic array. On `start` it parallel-loads all `ROWS` `shift_reg` instances in one cycle, then shifts each row out with a one-cycle skew per row, producing the diagonal wavefront the array expects. It drives only the `ctrl_code` bus and row-valid flags; the shift registers and their data paths sit beside it.

---
 rtl/systolic_pkg.sv | 24 ++
 rtl/shift_reg_sequencer_skew_window.sv | 27 ++
 rtl/shift_reg_sequencer.sv | 138 +++++++++++++
 tb/tb_shift_reg_sequencer.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types for the systolic array row-feed control path: shift_reg
// control codes, sequencer states and the skew-window membership test.
package systolic_pkg;

    typedef enum logic [1:0] {
        CTRL_HOLD  = 2'b00,
        CTRL_LOAD  = 2'b01,
        CTRL_WRITE = 2'b10,
        CTRL_READ  = 2'b11
    } ctrl_code_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_SHIFT = 2'b10,
        ST_DONE  = 2'b11
    } seq_state_t;

    // Row `row` is in its read window when row <= t < row + length.
    function automatic logic in_read_window(input int t, input int row, input int length);
        return (t >= row) && (t < row + length);
    endfunction

endpackage

// File: rtl/shift_reg_sequencer_skew_window.sv
// Combinational decode of the shift counter into the per-row READ mask,
// giving each row a LENGTH-cycle window delayed by one cycle per row.
module skew_window
    import systolic_pkg::*;
#(
    parameter int LENGTH = 4,
    parameter int ROWS   = 4,
    parameter int TW     = 3
) (
    input  logic [TW-1:0]     t_i,
    input  logic              en_i,
    output logic [0:ROWS-1]   read_mask_o
);

    // Per-row window membership, forced low outside the SHIFT phase.
    always_comb begin
        read_mask_o = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (en_i) begin
                read_mask_o[r] = in_read_window(int'(t_i), r, LENGTH);
            end else begin
                read_mask_o[r] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/shift_reg_sequencer.sv
// Load-then-skewed-shift sequencer for the systolic array row shift registers.
// Every output is a flop; next values are decoded from the next state/counter.
module shift_reg_sequencer
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LENGTH     = 4,
    parameter int ROWS       = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   abort,
    output logic [0:ROWS-1][1:0]   ctrl_code,
    output logic [0:ROWS-1]        row_valid,
    output logic                   busy,
    output logic                   done
);

    localparam int TW = $clog2(LENGTH + ROWS);
    localparam logic [TW-1:0] T_LAST = TW'(LENGTH + ROWS - 2);

    if (DATA_WIDTH < 1 || LENGTH < 1 || ROWS < 1) begin : g_param_check
        $error("shift_reg_sequencer: DATA_WIDTH, LENGTH and ROWS must be >= 1");
    end

    seq_state_t               state_q, state_d;
    logic [TW-1:0]            t_q, t_d;
    logic [0:ROWS-1][1:0]     ctrl_q, ctrl_d;
    logic [0:ROWS-1]          row_valid_q, row_valid_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     shift_en_s;
    logic [0:ROWS-1]          read_mask_s;

    // Next state and counter; abort beats start and cancels any active phase.
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        case (state_q)
            ST_IDLE: begin
                t_d = '0;
                if (start && !abort) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                t_d = '0;
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    t_d     = '0;
                end else if (t_q == T_LAST) begin
                    state_d = ST_DONE;
                    t_d     = '0;
                end else begin
                    state_d = ST_SHIFT;
                    t_d     = t_q + TW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                t_d     = '0;
            end
            default: begin
                state_d = ST_IDLE;
                t_d     = '0;
            end
        endcase
    end

    assign shift_en_s = (state_d == ST_SHIFT);

    skew_window #(
        .LENGTH (LENGTH),
        .ROWS   (ROWS),
        .TW     (TW)
    ) u_skew_window (
        .t_i         (t_d),
        .en_i        (shift_en_s),
        .read_mask_o (read_mask_s)
    );

    // Output next values; row_valid mirrors last cycle's READ unless the pass ends in IDLE.
    always_comb begin
        ctrl_d      = '0;
        row_valid_d = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (state_d == ST_LOAD) begin
                ctrl_d[r] = CTRL_LOAD;
            end else if (read_mask_s[r]) begin
                ctrl_d[r] = CTRL_READ;
            end else begin
                ctrl_d[r] = CTRL_HOLD;
            end
            if (state_d != ST_IDLE) begin
                row_valid_d[r] = (ctrl_q[r] == CTRL_READ);
            end else begin
                row_valid_d[r] = 1'b0;
            end
        end
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            t_q         <= '0;
            ctrl_q      <= '0;
            row_valid_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            t_q         <= t_d;
            ctrl_q      <= ctrl_d;
            row_valid_q <= row_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign ctrl_code = ctrl_q;
    assign row_valid = row_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Directed bench for shift_reg_sequencer: default 4x4 instance plus the
// ROWS=1/LENGTH=1 and ROWS=3/LENGTH=5 corner instances.
module tb_shift_reg_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;

    logic              start_a, abort_a, busy_a, done_a;
    logic [0:3][1:0]   ctrl_a;
    logic [0:3]        rv_a;

    logic              start_b, abort_b, busy_b, done_b;
    logic [0:0][1:0]   ctrl_b;
    logic [0:0]        rv_b;

    logic              start_c, abort_c, busy_c, done_c;
    logic [0:2][1:0]   ctrl_c;
    logic [0:2]        rv_c;

    int checks = 0;
    int errors = 0;

    // Expected per-cycle values, cycle 1 = LOAD. Rows packed row0 in the MSBs.
    int exp_ctrl_a [1:10] = '{8'h55, 8'hC0, 8'hF0, 8'hFC, 8'hFF, 8'h3F, 8'h0F, 8'h03, 8'h00, 8'h00};
    int exp_rv_a   [1:10] = '{4'h0, 4'h0, 4'h8, 4'hC, 4'hE, 4'hF, 4'h7, 4'h3, 4'h1, 4'h0};
    int exp_ctrl_b [1:10] = '{2'h1, 2'h3, 2'h0, 2'h0, 2'h0, 2'h0, 2'h0, 2'h0, 2'h0, 2'h0};
    int exp_rv_b   [1:10] = '{1'h0, 1'h0, 1'h1, 1'h0, 1'h0, 1'h0, 1'h0, 1'h0, 1'h0, 1'h0};
    int exp_ctrl_c [1:10] = '{6'h15, 6'h30, 6'h3C, 6'h3F, 6'h3F, 6'h3F, 6'h0F, 6'h03, 6'h00, 6'h00};
    int exp_rv_c   [1:10] = '{3'h0, 3'h0, 3'h4, 3'h6, 3'h7, 3'h7, 3'h7, 3'h3, 3'h1, 3'h0};

    shift_reg_sequencer #(.DATA_WIDTH(8), .LENGTH(4), .ROWS(4)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .start(start_a), .abort(abort_a),
        .ctrl_code(ctrl_a), .row_valid(rv_a), .busy(busy_a), .done(done_a)
    );

    shift_reg_sequencer #(.DATA_WIDTH(8), .LENGTH(1), .ROWS(1)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b), .abort(abort_b),
        .ctrl_code(ctrl_b), .row_valid(rv_b), .busy(busy_b), .done(done_b)
    );

    shift_reg_sequencer #(.DATA_WIDTH(8), .LENGTH(5), .ROWS(3)) u_dut_c (
        .clk(clk), .reset_n(reset_n), .start(start_c), .abort(abort_c),
        .ctrl_code(ctrl_c), .row_valid(rv_c), .busy(busy_c), .done(done_c)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string tag, input int ctrl, input int rv, input int bsy, input int dn);
        check_val({tag, " ctrl_a"}, 32'(ctrl_a), 32'(ctrl));
        check_val({tag, " rv_a"},   32'(rv_a),   32'(rv));
        check_val({tag, " busy_a"}, 32'(busy_a), 32'(bsy));
        check_val({tag, " done_a"}, 32'(done_a), 32'(dn));
    endtask

    // Drives one 4x4 pass; optionally pulses start in cycles 3, 9 (ignored) and 10 (accepted).
    task automatic run_pass_a(input bit pulse_starts);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            check_a($sformatf("pass c%0d", c), exp_ctrl_a[c], exp_rv_a[c],
                    (c <= 9) ? 1 : 0, (c == 9) ? 1 : 0);
            start_a = pulse_starts && (c == 3 || c == 9 || c == 10);
            tick();
        end
        start_a = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        start_a = 1'b0; abort_a = 1'b0;
        start_b = 1'b0; abort_b = 1'b0;
        start_c = 1'b0; abort_c = 1'b0;

        repeat (4) tick();
        check_a("reset", 0, 0, 0, 0);
        check_val("reset busy_b", 32'(busy_b), 32'd0);
        check_val("reset busy_c", 32'(busy_c), 32'd0);
        reset_n = 1'b1;
        tick();
        check_a("post_reset", 0, 0, 0, 0);

        // Full pass with ignored start pulses, then the cycle-10 start lands in LOAD.
        run_pass_a(1'b1);
        check_a("restart c11", 8'h55, 0, 1, 0);

        // Abort during SHIFT at t=3.
        repeat (4) tick();
        check_a("pre_abort t3", 8'hFF, 4'hE, 1, 0);
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        check_a("abort", 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check_val($sformatf("abort idle%0d done_a", i), 32'(done_a), 32'd0);
            check_val($sformatf("abort idle%0d busy_a", i), 32'(busy_a), 32'd0);
        end

        // start and abort together in IDLE.
        start_a = 1'b1;
        abort_a = 1'b1;
        tick();
        start_a = 1'b0;
        abort_a = 1'b0;
        check_a("start_abort", 0, 0, 0, 0);
        tick();
        check_a("start_abort+1", 0, 0, 0, 0);

        // Asynchronous reset in the middle of SHIFT at t=2.
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (3) tick();
        check_a("pre_rst t2", 8'hFC, 4'hC, 1, 0);
        #2;
        reset_n = 1'b0;
        #1;
        check_a("rst_mid", 0, 0, 0, 0);
        tick();
        check_a("rst_mid hold", 0, 0, 0, 0);
        reset_n = 1'b1;
        tick();
        check_a("rst_mid release", 0, 0, 0, 0);
        run_pass_a(1'b0);
        check_a("after_pass idle", 0, 0, 0, 0);

        // Corner parameter instances run side by side.
        start_b = 1'b1;
        start_c = 1'b1;
        tick();
        start_b = 1'b0;
        start_c = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            check_val($sformatf("r1l1 c%0d ctrl", c), 32'(ctrl_b), 32'(exp_ctrl_b[c]));
            check_val($sformatf("r1l1 c%0d rv",   c), 32'(rv_b),   32'(exp_rv_b[c]));
            check_val($sformatf("r1l1 c%0d busy", c), 32'(busy_b), (c <= 3) ? 32'd1 : 32'd0);
            check_val($sformatf("r1l1 c%0d done", c), 32'(done_b), (c == 3) ? 32'd1 : 32'd0);
            check_val($sformatf("r3l5 c%0d ctrl", c), 32'(ctrl_c), 32'(exp_ctrl_c[c]));
            check_val($sformatf("r3l5 c%0d rv",   c), 32'(rv_c),   32'(exp_rv_c[c]));
            check_val($sformatf("r3l5 c%0d busy", c), 32'(busy_c), (c <= 9) ? 32'd1 : 32'd0);
            check_val($sformatf("r3l5 c%0d done", c), 32'(done_c), (c == 9) ? 32'd1 : 32'd0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
